uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  UART transmitter (8N1, LSB first) with an internal byte FIFO. It is the transmit-side counterpart
//  of the project's UART receiver and shares its baud parameters, so both ends of the link agree.
//  Logic writes bytes into the FIFO; the serializer drains them onto tx back-to-back.
// PARAMETERS
//  BAUD_RATE   9600      line bit rate, bits/s
//  CLK_FREQ    25000000  clk frequency, Hz
//  BAUD_TICK   CLK_FREQ/BAUD_RATE  clk cycles per bit (2604 at defaults); must be >= 2
//  FIFO_AW     3         FIFO address width; depth = 2**FIFO_AW (8)
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  reset       in   1        asynchronous, active-high
//  wr_en       in   1        write strobe; byte accepted on an edge with wr_en=1 and full=0
//  wr_data     in   8        byte to send
//  full        out  1        FIFO holds 2**FIFO_AW bytes
//  empty       out  1        FIFO holds 0 bytes (the byte in the shifter is not counted)
//  overflow    out  1        sticky: set by a write attempted while full; cleared only by reset
//  tx          out  1        serial line, idle high
//  tx_busy     out  1        1 whenever state != IDLE
//  tx_done     out  1        one-cycle pulse on the edge that ends a stop bit
// BEHAVIOUR
//  Reset (async, any time, including mid-frame): tx=1, tx_busy=0, tx_done=0, overflow=0, full=0,
//   empty=1, FIFO pointers and count=0, state=IDLE, baud counter=0, bit index=0. A partial frame is abandoned.
//  FIFO: registered count 0..2**FIFO_AW; full=(count==depth), empty=(count==0), both registered
//   and updated on the same edge as count. Write while full: data dropped, overflow<=1, count unchanged.
//   Write and pop on the same edge: count unchanged, both take effect. A write while full is rejected
//   even if a pop happens on the same edge. Pointers wrap modulo depth.
//  FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..BAUD_TICK-1; each bit lasts exactly BAUD_TICK cycles.
//   IDLE : tx=1. If !empty: pop the head byte into the shift register, tx<=0, counter<=0, -> START.
//   START: tx=0. At counter==BAUD_TICK-1: counter<=0, bit index<=0, tx<=shift[0], -> DATA.
//   DATA : at counter==BAUD_TICK-1: shift right; if bit index<7: index++, tx<=next bit;
//          else tx<=1, -> STOP.
//   STOP : tx=1. At counter==BAUD_TICK-1: tx_done<=1; if !empty: pop, tx<=0, -> START
//          (no idle gap); else -> IDLE.
//  Latency: write on edge N into an empty FIFO with FSM in IDLE -> pop and tx falls on edge N+1.
//  Frame = 10*BAUD_TICK cycles. Consecutive queued bytes produce contiguous frames.
//  Bytes written during a frame are queued and never corrupt the byte in the shifter.
//  tx is driven from a register (glitch-free). tx_done is 0 on every cycle except the stop-end edge.
// TESTING  (bench uses CLK_FREQ=16, BAUD_RATE=1 -> BAUD_TICK=16, FIFO_AW=2)
//  1 Single byte: write 0x55 in idle -> tx falls 1 cycle later. Line bits (16 cycles each):
//    0,1,0,1,0,1,0,1,0,1. tx_done pulses once at cycle 160. tx_busy is high for exactly 160 cycles.
//  2 Back-to-back: write 0xA5,0x3C,0xFF on consecutive cycles -> three contiguous 160-cycle frames,
//    no idle high between stop and next start. The receiver model decodes A5,3C,FF. tx_done pulses 3 times.
//  3 Full/overflow: write 6 bytes in 6 cycles from idle -> first byte popped to the shifter, 4 queued,
//    full=1. The 6th write is dropped and overflow=1 (sticky). Only the first 5 bytes are transmitted.
//  4 Simultaneous write+pop: with count=1, time a write to the STOP-end edge -> count stays 1, byte order preserved.
//  5 Reset mid-frame: assert reset during DATA bit 3 of 0x0F -> tx=1 immediately and all outputs
//    take their reset values. After release, a write of 0x81 sends a clean frame 0,1,0,0,0,0,0,0,1,1.
//  6 Loopback: connect tx to the project receiver at default parameters and send 0x00..0xFF
//    -> every rx_data matches, with one rx_ready per byte.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 LSB-first UART transmitter fed by a small byte FIFO.
// Queued bytes go out as contiguous frames; tx always comes straight from a flop.
module uart_tx_fifo #(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_TICK = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_AW   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int                 DEPTH     = 2 ** FIFO_AW;
  localparam int                 CW        = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CW-1:0]      TICK_LAST = CW'(BAUD_TICK - 1);
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_next;
  logic               push, pop;
  logic [7:0]         head;

  state_t             state, state_next;
  logic [CW-1:0]      baud_cnt, baud_cnt_next;
  logic [2:0]         bit_idx, bit_idx_next;
  logic [7:0]         shift, shift_next;
  logic               tx_next, done_next;
  logic               bit_end;

  // A write while full is refused even if the serializer pops on the same edge.
  assign push       = wr_en && !full;
  assign count_next = count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
  assign head       = mem[rd_ptr];
  assign bit_end    = (baud_cnt == TICK_LAST);
  assign tx_busy    = (state != IDLE);

  // NOTE: reset is asynchronous, so it sits in the sensitivity list next to the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_next = bit_end ? '0 : baud_cnt + CW'(1);
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    tx_next       = tx;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (pop) begin
          shift_next = head;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_next = '0;
          tx_next      = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx != 3'd7) begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift[1];
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_next = 1'b1;
          if (pop) begin
            shift_next = head;
            tx_next    = 1'b0;
          end else begin
            tx_next = 1'b1;
          end
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  // NOTE: state-holding flops use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx       <= tx_next;
      tx_done  <= done_next;
    end
  end

endmodule
